// File: rtl/ucaspian_pkg.sv
// Shared types and constants for the uCaspian axon/synapse datapath.
package ucaspian_pkg;

  localparam int unsigned SYN_ADDR_W  = 10;
  localparam int unsigned SYN_COUNT_W = 11;

  // One config RAM entry: outgoing synapse range of a neuron.
  typedef struct packed {
    logic [SYN_COUNT_W-1:0] count;
    logic [SYN_ADDR_W-1:0]  start;
  } axon_entry_t;

  typedef enum logic [1:0] {IDLE, READ, ISSUE} axon_state_t;

endpackage

// File: rtl/ucaspian_axon_seq_if.sv
// Address-carrying valid/ready handshake used for fire events and synapse requests.
interface ucaspian_axon_seq_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] addr;
  logic             vld;
  logic             rdy;

  modport master (output addr, output vld, input rdy);
  modport slave  (input addr, input vld, output rdy);

endinterface

// File: rtl/ucaspian_fifo.sv
// Synchronous FIFO with flush; pop data is the current head (show-ahead).
module ucaspian_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ucaspian_axon_seq.sv
// Axon sequencer: turns neuron fire events into a stream of synapse addresses
// using a per-neuron {count, start} config RAM.
module ucaspian_axon_seq
  import ucaspian_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 256,
  parameter int unsigned FIFO_DEPTH  = 16,
  localparam int unsigned NW         = $clog2(NUM_NEURONS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear_act,
  input  logic                clear_config,
  output logic                clear_done,
  output logic                step_done,
  input  logic [NW-1:0]       cfg_addr,
  input  logic [7:0]          cfg_value,
  input  logic [2:0]          cfg_byte,
  input  logic                cfg_enable,
  ucaspian_axon_seq_if.slave  fire,
  ucaspian_axon_seq_if.master syn
);

  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [NW-1:0] fifo_head;

  axon_state_t            state_q;
  logic [SYN_COUNT_W-1:0] remaining_q;
  logic [SYN_ADDR_W-1:0]  syn_addr_q;
  logic                   syn_vld_q;
  logic                   step_done_q, clear_done_q;

  assign fire.rdy  = ~fifo_full & ~reset & ~clear_act & ~clear_config;
  assign fifo_push = fire.vld & fire.rdy;
  assign fifo_pop  = (state_q == IDLE) & enable & ~fifo_empty & ~clear_act & ~reset;

  ucaspian_fifo #(
    .WIDTH (NW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (clear_act),
    .push      (fifo_push),
    .push_data (fire.addr),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Config staging: bytes 0-2 build the entry, byte 3 completes it and
  // schedules the RAM write for the following cycle.
  axon_entry_t   stage_q;
  logic          commit_q;
  logic [NW-1:0] commit_addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q       <= '0;
      commit_q      <= 1'b0;
      commit_addr_q <= '0;
    end else begin
      commit_q <= 1'b0;
      if (!clear_config && cfg_enable) begin
        case (cfg_byte)
          3'd0: stage_q.start[7:0]  <= cfg_value;
          3'd1: stage_q.start[9:8]  <= cfg_value[1:0];
          3'd2: stage_q.count[7:0]  <= cfg_value;
          3'd3: begin
            stage_q.count[10:8] <= cfg_value[2:0];
            commit_q            <= 1'b1;
            commit_addr_q       <= cfg_addr;
          end
          default: ;
        endcase
      end
    end
  end

  logic [NW-1:0] sweep_q;
  logic          sweep_done_q, sweep_last;

  assign sweep_last = (sweep_q == NW'(NUM_NEURONS - 1));

  always_ff @(posedge clk) begin
    if (reset || !clear_config) begin
      sweep_q      <= '0;
      sweep_done_q <= 1'b0;
    end else if (!sweep_done_q) begin
      sweep_q <= sweep_q + NW'(1);
      if (sweep_last) sweep_done_q <= 1'b1;
    end
  end

  // Single write port shared by the clear sweep and config commits; the sweep wins.
  logic          ram_we;
  logic [NW-1:0] ram_waddr;
  axon_entry_t   ram_wdata;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = commit_addr_q;
    ram_wdata = stage_q;
    if (clear_config) begin
      ram_we    = ~sweep_done_q;
      ram_waddr = sweep_q;
      ram_wdata = '0;
    end else if (commit_q) begin
      ram_we = 1'b1;
    end
  end

  axon_entry_t cfg_mem [NUM_NEURONS];
  axon_entry_t rd_entry_q;

  // Read address is the FIFO head, so the entry is ready in READ after a pop.
  always_ff @(posedge clk) begin
    if (ram_we) cfg_mem[ram_waddr] <= ram_wdata;
    rd_entry_q <= cfg_mem[fifo_head];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      syn_addr_q  <= '0;
      syn_vld_q   <= 1'b0;
    end else if (clear_act) begin
      state_q   <= IDLE;
      syn_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (fifo_pop) state_q <= READ;
        READ: begin
          if (rd_entry_q.count == '0) begin
            state_q <= IDLE;
          end else begin
            syn_addr_q  <= rd_entry_q.start;
            remaining_q <= rd_entry_q.count;
            syn_vld_q   <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (syn.rdy) begin
            syn_addr_q  <= syn_addr_q + SYN_ADDR_W'(1);
            remaining_q <= remaining_q - SYN_COUNT_W'(1);
            if (remaining_q == SYN_COUNT_W'(1)) begin
              syn_vld_q <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_done_q  <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      step_done_q  <= ~fire.vld & fifo_empty & (state_q == IDLE) & ~syn_vld_q;
      clear_done_q <= clear_act | (clear_config & (sweep_done_q | sweep_last));
    end
  end

  assign syn.addr   = syn_addr_q;
  assign syn.vld    = syn_vld_q;
  assign step_done  = step_done_q;
  assign clear_done = clear_done_q;

endmodule

// File: tb/tb_ucaspian_axon_seq.sv
// Scoreboard bench for ucaspian_axon_seq: directed fire/config vectors, monitor checks syn stream.
module tb_ucaspian_axon_seq;

  localparam int NN = 256;
  localparam int FD = 16;

  logic       clk = 1'b0;
  logic       reset, enable, clear_act, clear_config, cfg_enable;
  logic       clear_done, step_done;
  logic [7:0] cfg_addr, cfg_value;
  logic [2:0] cfg_byte;

  always #5 clk = ~clk;

  ucaspian_axon_seq_if #(.WIDTH(8))  fire_if ();
  ucaspian_axon_seq_if #(.WIDTH(10)) syn_if ();

  ucaspian_axon_seq #(
    .NUM_NEURONS (NN),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .clear_act    (clear_act),
    .clear_config (clear_config),
    .clear_done   (clear_done),
    .step_done    (step_done),
    .cfg_addr     (cfg_addr),
    .cfg_value    (cfg_value),
    .cfg_byte     (cfg_byte),
    .cfg_enable   (cfg_enable),
    .fire         (fire_if),
    .syn          (syn_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[$];
  int m_start[NN];
  int m_count[NN];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every syn handshake pops one expected address; stalls must hold.
  logic       prev_stall = 1'b0;
  logic [9:0] prev_addr  = '0;
  int         mon_e;

  always @(negedge clk) begin
    if (prev_stall) begin
      check("syn_hold_vld", int'(syn_if.vld), 1);
      check("syn_hold_addr", int'(syn_if.addr), int'(prev_addr));
    end
    if (!reset && !clear_act && syn_if.vld && syn_if.rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL syn_unexpected: got addr %0d, expected no request (cycle %0d)",
                 syn_if.addr, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("syn_addr", int'(syn_if.addr), mon_e);
      end
    end
    prev_stall = syn_if.vld && !syn_if.rdy && !reset && !clear_act;
    prev_addr  = syn_if.addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input int n, input int b, input int v);
    cfg_addr   = 8'(n);
    cfg_byte   = 3'(b);
    cfg_value  = 8'(v);
    cfg_enable = 1'b1;
    tick();
    cfg_enable = 1'b0;
  endtask

  // Junk bytes 4-6 are interleaved; they must not disturb the staged entry.
  task automatic cfg_entry(input int n, input int start, input int count);
    cfg_wr(n, 0, start & 255);
    cfg_wr(n, 4, 8'hff);
    cfg_wr(n, 1, start >> 8);
    cfg_wr(n, 5, 8'hff);
    cfg_wr(n, 2, count & 255);
    cfg_wr(n, 6, 8'hff);
    cfg_wr(n, 3, count >> 8);
    tick();
    m_start[n] = start;
    m_count[n] = count;
  endtask

  task automatic push_exp(input int n);
    for (int i = 0; i < m_count[n]; i++) exp_q.push_back((m_start[n] + i) % 1024);
  endtask

  task automatic fire(input int n, input bit expect_out, output int hs_cyc);
    int k;
    k = 0;
    fire_if.addr = 8'(n);
    fire_if.vld  = 1'b1;
    @(negedge clk);
    while (!fire_if.rdy && k < 200) begin
      @(negedge clk);
      k++;
    end
    hs_cyc = cyc;
    if (!fire_if.rdy) begin
      checks++;
      errors++;
      $display("FAIL fire_timeout: neuron %0d not accepted, expected fire_rdy=1", n);
    end else if (expect_out) begin
      push_exp(n);
    end
    tick();
    fire_if.vld = 1'b0;
  endtask

  task automatic wait_vld(output int c);
    int k;
    k = 0;
    @(negedge clk);
    while (!syn_if.vld && k < 100) begin
      @(negedge clk);
      k++;
    end
    c = cyc;
    if (!syn_if.vld) begin
      checks++;
      errors++;
      $display("FAIL vld_timeout: got syn_vld=0, expected 1");
    end
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && step_done) && k < bound) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", int'(exp_q.size() == 0 && step_done), 1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  int t, c;
  int nl[4] = '{5, 7, 11, 9};
  bit pat[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    reset        = 1'b1;
    enable       = 1'b1;
    clear_act    = 1'b0;
    clear_config = 1'b0;
    cfg_enable   = 1'b0;
    cfg_addr     = '0;
    cfg_value    = '0;
    cfg_byte     = '0;
    fire_if.addr = '0;
    fire_if.vld  = 1'b0;
    syn_if.rdy   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_syn_vld", int'(syn_if.vld), 0);
    check("rst_syn_addr", int'(syn_if.addr), 0);
    check("rst_clear_done", int'(clear_done), 0);
    check("rst_step_done", int'(step_done), 0);
    check("rst_fire_rdy", int'(fire_if.rdy), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_fire_rdy", int'(fire_if.rdy), 1);
    tick();

    cfg_entry(5, 100, 4);
    cfg_entry(7, 1022, 3);
    cfg_entry(9, 200, 0);
    cfg_entry(11, 500, 2);

    // Basic sequence and latency
    syn_if.rdy = 1'b1;
    fire(5, 1'b1, t);
    wait_vld(c);
    check("latency", c - t, 3);
    wait_idle(100);
    check("step_done_after", int'(step_done), 1);

    // Wrap with stalls
    syn_if.rdy = 1'b0;
    fire(7, 1'b1, t);
    wait_vld(c);
    for (int i = 0; i < 5; i++) begin
      tick();
      syn_if.rdy = pat[i];
    end
    tick();
    syn_if.rdy = 1'b1;
    wait_idle(100);

    // Zero-count neuron followed by a real one
    fire(9, 1'b1, t);
    fire(5, 1'b1, c);
    wait_vld(c);
    check("gap_after_zero", c - t, 5);
    wait_idle(100);

    // Fill FIFO with popping disabled, then drain in order
    enable     = 1'b0;
    syn_if.rdy = 1'b0;
    for (int i = 0; i < FD; i++) fire(nl[i % 4], 1'b1, t);
    fire_if.addr = 8'd5;
    fire_if.vld  = 1'b1;
    @(negedge clk);
    check("full_fire_rdy", int'(fire_if.rdy), 0);
    tick();
    fire_if.vld = 1'b0;
    enable      = 1'b1;
    syn_if.rdy  = 1'b1;
    wait_idle(1000);

    // clear_act mid-ISSUE with three queued events
    syn_if.rdy = 1'b0;
    fire(5, 1'b0, t);
    wait_vld(c);
    tick();
    fire(5, 1'b0, t);
    fire(7, 1'b0, t);
    fire(11, 1'b0, t);
    clear_act = 1'b1;
    @(negedge clk);
    check("clr_act_fire_rdy", int'(fire_if.rdy), 0);
    tick();
    @(negedge clk);
    check("clr_act_syn_vld", int'(syn_if.vld), 0);
    check("clr_act_done", int'(clear_done), 1);
    tick();
    clear_act  = 1'b0;
    syn_if.rdy = 1'b1;
    tick();
    @(negedge clk);
    check("clr_act_done_low", int'(clear_done), 0);
    repeat (10) tick();
    @(negedge clk);
    check("clr_act_fifo_empty", int'(step_done), 1);
    tick();
    fire(5, 1'b1, t);
    wait_idle(100);

    // Reset mid-iteration aborts
    syn_if.rdy = 1'b0;
    fire(5, 1'b0, t);
    wait_vld(c);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("mid_rst_syn_vld", int'(syn_if.vld), 0);
    check("mid_rst_syn_addr", int'(syn_if.addr), 0);
    tick();
    reset      = 1'b0;
    syn_if.rdy = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check("mid_rst_idle", int'(step_done), 1);
    tick();

    // clear_config sweep
    clear_config = 1'b1;
    for (int k = 0; k < NN + 2; k++) begin
      @(negedge clk);
      if (k == 0) check("clr_cfg_fire_rdy", int'(fire_if.rdy), 0);
      if (k == NN - 1) check("clr_cfg_done_early", int'(clear_done), 0);
      if (k >= NN) check("clr_cfg_done", int'(clear_done), 1);
      tick();
    end
    clear_config = 1'b0;
    for (int n = 0; n < NN; n++) m_count[n] = 0;
    fire(5, 1'b1, t);
    fire(7, 1'b1, t);
    fire(11, 1'b1, t);
    repeat (20) tick();
    @(negedge clk);
    check("clr_cfg_no_vld", int'(syn_if.vld), 0);
    check("clr_cfg_idle", int'(step_done), 1);

    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
